// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 controller.
// MC_CTRL_JAL_EN adds the JAL state and its opcode decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
`ifdef MC_CTRL_JAL_EN
    , S_JAL
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: return 1'b1;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decode: fixed add/sub, or funct3/funct7 decode for R/I-type.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type, so addi never becomes sub
          3'b000:  alu_control = (op5 & funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32 Moore controller; JAL support behind MC_CTRL_JAL_EN.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       sign,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_op
);

  state_t     r_state, w_next;
  logic       w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_illegal;
  logic       w_branch_taken;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:            w_next = S_JAL;
`endif
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
`ifdef MC_CTRL_JAL_EN
      S_JAL:     w_next = S_ALUWB;
`endif
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  w_branch_taken = zero;
      3'b001:  w_branch_taken = ~zero;
      3'b100:  w_branch_taken = sign;
      default: w_branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    adr_src     = ADR_PC;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        w_illegal = ~op_supported(op);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = ADR_ALUOUT;
      S_MEMWB: begin
        result_src  = RES_RDATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = ADR_ALUOUT;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        w_alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        w_alu_op   = ALUOP_SUB;
        w_pc_write = w_branch_taken;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        w_pc_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op      (w_alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7      (funct7),
    .alu_control (alu_control)
  );

  // Strobes are masked by rst_n directly so they drop before the first reset edge
  assign pc_write   = rst_n & w_pc_write;
  assign ir_write   = rst_n & w_ir_write;
  assign mem_write  = rst_n & w_mem_write;
  assign reg_write  = rst_n & w_reg_write;
  assign illegal_op = rst_n & w_illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; define MC_CTRL_JAL_EN to exercise JAL.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, zero, sign;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int total = 0;
  int bad   = 0;

  // {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu_control, illegal_op}
  localparam logic [14:0] V_FETCH   = 15'b11000_10_00_10_000_0;
  localparam logic [14:0] V_DECODE  = 15'b00000_00_01_01_000_0;
  localparam logic [14:0] V_DEC_ILL = 15'b00000_00_01_01_000_1;
  localparam logic [14:0] V_MEMADR  = 15'b00000_00_10_01_000_0;
  localparam logic [14:0] V_MEMREAD = 15'b00100_00_00_00_000_0;
  localparam logic [14:0] V_MEMWB   = 15'b00001_01_00_00_000_0;
  localparam logic [14:0] V_MEMWR   = 15'b00110_00_00_00_000_0;
  localparam logic [14:0] V_EXECR_S = 15'b00000_00_10_00_001_0;
  localparam logic [14:0] V_EXECI_A = 15'b00000_00_10_01_000_0;
  localparam logic [14:0] V_EXECI_O = 15'b00000_00_10_01_011_0;
  localparam logic [14:0] V_ALUWB   = 15'b00001_00_00_00_000_0;
  localparam logic [14:0] V_BR_NT   = 15'b00000_00_10_00_001_0;
  localparam logic [14:0] V_BR_T    = 15'b10000_00_10_00_001_0;
  localparam logic [14:0] V_JAL     = 15'b10000_00_01_10_000_0;

  mc_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .zero        (zero),
    .sign        (sign),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {pc_write, ir_write, adr_src, mem_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_control, illegal_op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] strobes;
    rst_n = 1'b1; op = OP_LOAD; funct3 = 3'b010; funct7 = 1'b0; #1;
    total++;
    if (obs() !== V_FETCH) begin
      bad++; $display("FAIL rst_first_fetch got=%b exp=%b", obs(), V_FETCH);
    end
    step(); step(); step();
    total++;
    if (obs() !== V_MEMREAD) begin
      bad++; $display("FAIL rst_memread got=%b exp=%b", obs(), V_MEMREAD);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      strobes = {pc_write, ir_write, mem_write, reg_write, illegal_op};
      total++;
      if (strobes !== 5'b0) begin
        bad++; $display("FAIL rst_strobes cyc%0d got=%b exp=00000", i, strobes);
      end
      total++;
      if (dut.r_state !== S_FETCH) begin
        bad++; $display("FAIL rst_state cyc%0d got=%0d exp=%0d", i, dut.r_state, S_FETCH);
      end
    end
    rst_n = 1'b1; #1;
    total++;
    if (obs() !== V_FETCH) begin
      bad++; $display("FAIL rst_release_fetch got=%b exp=%b", obs(), V_FETCH);
    end
    step();
    total++;
    if (obs() !== V_DECODE) begin
      bad++; $display("FAIL rst_release_decode got=%b exp=%b", obs(), V_DECODE);
    end
    step(); step(); step(); step();
  endtask

  task automatic test_lw();
    logic [14:0] e [5];
    e = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
    op = OP_LOAD; funct3 = 3'b010; funct7 = 1'b0; #1;
    total++;
    if (imm_src !== IMM_I) begin
      bad++; $display("FAIL lw_imm got=%b exp=%b", imm_src, IMM_I);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL lw cyc%0d got=%b exp=%b", i + 1, obs(), e[i]);
      end
      step();
    end
    total++;
    if (obs() !== V_FETCH) begin
      bad++; $display("FAIL lw_next got=%b exp=%b", obs(), V_FETCH);
    end
  endtask

  task automatic test_sw();
    logic [14:0] e [4];
    e = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
    op = OP_STORE; funct3 = 3'b010; funct7 = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL sw cyc%0d got=%b exp=%b", i + 1, obs(), e[i]);
      end
      total++;
      if (imm_src !== IMM_S) begin
        bad++; $display("FAIL sw_imm cyc%0d got=%b exp=%b", i + 1, imm_src, IMM_S);
      end
      step();
    end
    total++;
    if (obs() !== V_FETCH) begin
      bad++; $display("FAIL sw_next got=%b exp=%b", obs(), V_FETCH);
    end
  endtask

  task automatic test_rtype_sub();
    logic [14:0] e [4];
    e = '{V_FETCH, V_DECODE, V_EXECR_S, V_ALUWB};
    op = OP_RTYPE; funct3 = 3'b000; funct7 = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL sub cyc%0d got=%b exp=%b", i + 1, obs(), e[i]);
      end
      step();
    end
    total++;
    if (obs() !== V_FETCH) begin
      bad++; $display("FAIL sub_next got=%b exp=%b", obs(), V_FETCH);
    end
  endtask

  task automatic test_itype();
    logic [2:0]  f3 [2];
    logic [14:0] ex [2];
    f3 = '{3'b000, 3'b110};
    ex = '{V_EXECI_A, V_EXECI_O};
    for (int k = 0; k < 2; k++) begin
      op = OP_ITYPE; funct3 = f3[k]; funct7 = 1'b1; #1;
      step(); step();
      total++;
      if (obs() !== ex[k]) begin
        bad++; $display("FAIL itype%0d exec got=%b exp=%b", k, obs(), ex[k]);
      end
      step();
      total++;
      if (obs() !== V_ALUWB) begin
        bad++; $display("FAIL itype%0d wb got=%b exp=%b", k, obs(), V_ALUWB);
      end
      step();
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3 [5];
    logic        z  [5];
    logic        s  [5];
    logic [14:0] ex [5];
    f3 = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b010};
    z  = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1};
    s  = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
    ex = '{V_BR_T, V_BR_NT, V_BR_T, V_BR_T, V_BR_NT};
    for (int k = 0; k < 5; k++) begin
      op = OP_BRANCH; funct3 = f3[k]; funct7 = 1'b0; zero = z[k]; sign = s[k]; #1;
      step(); step();
      total++;
      if (obs() !== ex[k]) begin
        bad++; $display("FAIL branch%0d got=%b exp=%b", k, obs(), ex[k]);
      end
      total++;
      if (imm_src !== IMM_B) begin
        bad++; $display("FAIL branch%0d_imm got=%b exp=%b", k, imm_src, IMM_B);
      end
      step();
      total++;
      if (obs() !== V_FETCH) begin
        bad++; $display("FAIL branch%0d_next got=%b exp=%b", k, obs(), V_FETCH);
      end
    end
    zero = 1'b0; sign = 1'b0;
  endtask

  task automatic test_jal();
`ifdef MC_CTRL_JAL_EN
    logic [14:0] e [4];
    e = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB};
`else
    logic [14:0] e [2];
    e = '{V_FETCH, V_DEC_ILL};
`endif
    op = OP_JAL; funct3 = 3'b000; funct7 = 1'b0; #1;
    total++;
    if (imm_src !== IMM_J) begin
      bad++; $display("FAIL jal_imm got=%b exp=%b", imm_src, IMM_J);
    end
    for (int i = 0; i < $size(e); i++) begin
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL jal cyc%0d got=%b exp=%b", i + 1, obs(), e[i]);
      end
      step();
    end
    total++;
    if (obs() !== V_FETCH) begin
      bad++; $display("FAIL jal_next got=%b exp=%b", obs(), V_FETCH);
    end
  endtask

  task automatic test_illegal();
    op = 7'b1111111; funct3 = 3'b000; funct7 = 1'b0; #1;
    total++;
    if (illegal_op !== 1'b0) begin
      bad++; $display("FAIL ill_fetch got=%b exp=0", illegal_op);
    end
    step();
    total++;
    if (obs() !== V_DEC_ILL) begin
      bad++; $display("FAIL ill_decode got=%b exp=%b", obs(), V_DEC_ILL);
    end
    step();
    total++;
    if (obs() !== V_FETCH) begin
      bad++; $display("FAIL ill_next got=%b exp=%b", obs(), V_FETCH);
    end
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct3 = '0; funct7 = 1'b0; zero = 1'b0; sign = 1'b0;
    step(); step();
    total++;
    if ({pc_write, ir_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
      bad++; $display("FAIL init_strobes got=%b exp=00000",
                      {pc_write, ir_write, mem_write, reg_write, illegal_op});
    end
    test_reset();
    test_lw();
    test_sw();
    test_rtype_sub();
    test_itype();
    test_branch();
    test_jal();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
